// File: rtl/npc_trap_pkg.sv
// Shared trap/halt definitions for the NPC core.
// Holds the EBREAK encoding and the halt-unit state type.
package npc_trap_pkg;

   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      REQ   = 2'd2,
      DONE  = 2'd3
   } halt_state_e;

endpackage

// File: rtl/ebreak_perf_counters.sv
// Cycle and retired-instruction counters reported with the halt.
// Ports: clock, reset_n, cyc_en, ret_en -> halt_cycles, halt_instret.
module ebreak_perf_counters (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cyc_en,
   input  logic        ret_en,
   output logic [63:0] halt_cycles,
   output logic [63:0] halt_instret
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         halt_cycles  <= '0;
         halt_instret <= '0;
      end else begin
         if (cyc_en) halt_cycles  <= halt_cycles + 64'd1;
         if (ret_en) halt_instret <= halt_instret + 64'd1;
      end
   end

endmodule

// File: rtl/ebreak_halt_unit.sv
// EBREAK halt unit: freezes the core on a retiring EBREAK, waits for
// the LSU to drain (bounded by DRAIN_MAX), then hands the exit code
// and trap PC to the harness over halt_valid/halt_ready.
// Ports: clock, reset_n, wb_valid/wb_inst/wb_pc, a0_value, lsu_busy,
//   stall_req, halt_valid, halt_ready, halt_code, halt_pc,
//   halt_timeout, halted.
// Macro EBREAK_HALT_PERF_EN adds halt_cycles and halt_instret.
module ebreak_halt_unit
   import npc_trap_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int DRAIN_MAX = 16
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            wb_valid,
   input  logic [31:0]     wb_inst,
   input  logic [XLEN-1:0] wb_pc,
   input  logic [XLEN-1:0] a0_value,
   input  logic            lsu_busy,
   output logic            stall_req,
   output logic            halt_valid,
   input  logic            halt_ready,
   output logic [XLEN-1:0] halt_code,
   output logic [XLEN-1:0] halt_pc,
   output logic            halt_timeout,
   output logic            halted
`ifdef EBREAK_HALT_PERF_EN
   ,
   output logic [63:0]     halt_cycles,
   output logic [63:0]     halt_instret
`endif
);

   localparam int CW = $clog2(DRAIN_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

   halt_state_e     state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] code_q, code_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            to_q, to_d;
   logic            hit;

   assign hit = wb_valid && (wb_inst == EBREAK_INST);

   // Combinational so the instruction after EBREAK never commits.
   assign stall_req = hit || (state_q != RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      pc_d    = pc_q;
      to_d    = to_q;
      unique case (state_q)
         RUN: begin
            if (hit) begin
               state_d = DRAIN;
               cnt_d   = '0;
               code_d  = a0_value;
               pc_d    = wb_pc;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            // A drain that finishes on the last allowed cycle
            // still counts as clean.
            if (!lsu_busy) begin
               state_d = REQ;
               to_d    = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = REQ;
               to_d    = 1'b1;
            end
         end
         REQ: begin
            if (halt_ready) state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         code_q  <= '0;
         pc_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         to_q    <= to_d;
      end
   end

   assign halt_valid   = (state_q == REQ);
   assign halted       = (state_q == DONE);
   assign halt_code    = code_q;
   assign halt_pc      = pc_q;
   assign halt_timeout = to_q;

`ifdef EBREAK_HALT_PERF_EN
   ebreak_perf_counters u_perf (
      .clock        (clock),
      .reset_n      (reset_n),
      .cyc_en       (state_q != DONE),
      .ret_en       (wb_valid && (state_q == RUN)),
      .halt_cycles  (halt_cycles),
      .halt_instret (halt_instret)
   );
`endif

endmodule
